// File: rtl/stream_delay_unit_pkg.sv
// Shared types for the stream delay stage: FSM state, debug view and the
// LFSR step function used to pick pseudo-random delays.
package stream_delay_unit_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } sdu_state_e;

    // Probe bundle so checkers can see the handshake FSM without extra ports.
    typedef struct packed {
        sdu_state_e state;
        logic       cnt_zero;
        logic       sample;
    } sdu_dbg_t;

    localparam int unsigned RandDelaySpan = 16;

    // Fibonacci step, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/stream_delay_unit_lfsr_16bit.sv
// 16-bit Fibonacci LFSR that steps only when en_i is high.
module lfsr_16bit
    import stream_delay_unit_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] out_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_o <= Seed;
        end else if (en_i) begin
            out_o <= lfsr16_next(out_o);
        end
    end

endmodule

// File: rtl/stream_delay_unit.sv
// Valid/ready delay stage: payload passes straight through, the handshake is
// held off for a fixed or LFSR-chosen number of cycles per transfer.
//
// Handshake: a transfer happens in a cycle where valid and ready are both high
// on the same side; upstream keeps valid_i and payload_i stable until then.
module stream_delay_unit
    import stream_delay_unit_pkg::*;
#(
    parameter bit          StallRandom = 1'b0,
    parameter int unsigned FixedDelay  = 1,
    parameter type         payload_t   = logic,
    parameter logic [15:0] Seed        = 16'hACE1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     clr_i,
    input  payload_t payload_i,
    input  logic     valid_i,
    output logic     ready_o,
    output payload_t payload_o,
    output logic     valid_o,
    input  logic     ready_i
);

    if (Seed == 16'h0000) begin : g_seed_check
        $error("stream_delay_unit: Seed must be nonzero");
    end

    assign payload_o = payload_i;

    if (!StallRandom && FixedDelay == 0) begin : g_pass
        assign valid_o = valid_i;
        assign ready_o = ready_i;

        logic unused_pass;
        assign unused_pass = clk_i ^ rst_ni ^ clr_i;
    end else begin : g_delay
        localparam int unsigned MaxDelay = (FixedDelay > RandDelaySpan) ? FixedDelay : RandDelaySpan;
        localparam int unsigned CntW     = $clog2(MaxDelay + 1);

        sdu_state_e      state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic [CntW-1:0] delay;
        logic            sample;
        sdu_dbg_t        dbg_unused;

        // A delay is consumed whenever a new transfer is seen from IDLE.
        assign sample = (state_q == ST_IDLE) && valid_i;

        if (StallRandom) begin : g_rand
            logic [15:0] lfsr;
            logic        unused_lfsr;

            lfsr_16bit #(.Seed(Seed)) u_lfsr (
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .en_i  (sample),
                .out_o (lfsr)
            );

            assign delay       = CntW'(lfsr[3:0]);
            assign unused_lfsr = ^lfsr[15:4];
        end else begin : g_fixed
            assign delay = CntW'(FixedDelay);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            valid_o = 1'b0;
            ready_o = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (delay == '0) begin
                            valid_o = 1'b1;
                            ready_o = ready_i;
                            if (!ready_i) begin
                                cnt_d   = '0;
                                state_d = ST_COUNT;
                            end
                        end else begin
                            cnt_d   = delay - CntW'(1);
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        valid_o = valid_i;
                        ready_o = ready_i & valid_i;
                        if (valid_i && ready_i) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Clear wins over every transition; outputs still reflect this cycle.
            if (clr_i) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end

        assign dbg_unused.state    = state_q;
        assign dbg_unused.cnt_zero = (cnt_q == '0);
        assign dbg_unused.sample   = sample;
    end

endmodule

// File: tb/tb_stream_delay_unit.sv
// Bench for stream_delay_unit: five instances (pass-through, fixed 3/2/5,
// random) share one stimulus bus; each test selects which outputs it checks.
module tb_stream_delay_unit;

    typedef logic [7:0] byte_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  clr = 1'b0;
    logic  valid_i = 1'b0;
    logic  ready_i = 1'b0;
    byte_t payload_i = '0;

    logic [4:0] vo, ro;
    byte_t      po [0:4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_delay_unit #(.StallRandom(1'b0), .FixedDelay(0), .payload_t(byte_t)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ro[0]), .payload_o(po[0]), .valid_o(vo[0]), .ready_i(ready_i));
    stream_delay_unit #(.StallRandom(1'b0), .FixedDelay(3), .payload_t(byte_t)) u_fd3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ro[1]), .payload_o(po[1]), .valid_o(vo[1]), .ready_i(ready_i));
    stream_delay_unit #(.StallRandom(1'b0), .FixedDelay(2), .payload_t(byte_t)) u_fd2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ro[2]), .payload_o(po[2]), .valid_o(vo[2]), .ready_i(ready_i));
    stream_delay_unit #(.StallRandom(1'b0), .FixedDelay(5), .payload_t(byte_t)) u_fd5 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ro[3]), .payload_o(po[3]), .valid_o(vo[3]), .ready_i(ready_i));
    stream_delay_unit #(.StallRandom(1'b1), .FixedDelay(1), .payload_t(byte_t), .Seed(16'hACE1)) u_rand (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .payload_i(payload_i), .valid_i(valid_i),
        .ready_o(ro[4]), .payload_o(po[4]), .valid_o(vo[4]), .ready_i(ready_i));

    // ---------------- checking helpers ----------------
    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_byte(input string name, input byte_t act, input byte_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        clr     = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference LFSR: shift right, new MSB = parity of bits 0,2,3,5.
    function automatic logic [15:0] model_lfsr_step(input logic [15:0] s);
        logic [15:0] fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
        return (s >> 1) | (fb << 15);
    endfunction

    typedef struct {
        logic  v;
        logic  r;
        byte_t p;
        logic  ev;
        logic  er;
    } vec_t;

    vec_t  tbl [19];
    byte_t exp_q [$];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        rst_n = 1'b0;
        to_sample();
        for (int i = 1; i < 5; i++) begin
            chk_bit($sformatf("reset_valid_o[%0d]", i), vo[i], 1'b0);
            chk_bit($sformatf("reset_ready_o[%0d]", i), ro[i], 1'b0);
        end
        chk_bit("reset_pass_ready_o", ro[0], 1'b1);
        to_drive();
        rst_n = 1'b1;

        // ---------------- pass-through, random toggling ----------------
        for (int c = 0; c < 40; c++) begin
            valid_i   = 1'($urandom_range(0, 1));
            ready_i   = 1'($urandom_range(0, 1));
            payload_i = 8'($urandom);
            to_sample();
            chk_bit($sformatf("pass_valid c%0d", c), vo[0], valid_i);
            chk_bit($sformatf("pass_ready c%0d", c), ro[0], ready_i);
            chk_byte($sformatf("pass_payload c%0d", c), po[0], payload_i);
            to_drive();
        end

        // ---------------- FixedDelay=3, table driven ----------------
        for (int c = 0; c < 19; c++) begin
            tbl[c].v  = (c >= 10 && c <= 17);
            tbl[c].r  = 1'b1;
            tbl[c].p  = (c <= 13) ? 8'hA5 : 8'h5A;
            tbl[c].ev = (c == 13 || c == 17);
            tbl[c].er = (c == 13 || c == 17);
        end
        do_reset();
        for (int c = 0; c < 19; c++) begin
            valid_i   = tbl[c].v;
            ready_i   = tbl[c].r;
            payload_i = tbl[c].p;
            to_sample();
            chk_bit($sformatf("fd3_valid c%0d", c), vo[1], tbl[c].ev);
            chk_bit($sformatf("fd3_ready c%0d", c), ro[1], tbl[c].er);
            chk_byte($sformatf("fd3_payload c%0d", c), po[1], tbl[c].p);
            to_drive();
        end

        // ---------------- FixedDelay=2, backpressure ----------------
        do_reset();
        payload_i = 8'h3C;
        for (int c = 0; c < 23; c++) begin
            valid_i = (c <= 20);
            ready_i = (c >= 20);
            to_sample();
            chk_bit($sformatf("fd2_valid c%0d", c), vo[2], (c >= 2 && c <= 20));
            chk_bit($sformatf("fd2_ready c%0d", c), ro[2], (c == 20));
            to_drive();
        end

        // ---------------- FixedDelay=5, clear mid-count ----------------
        do_reset();
        for (int c = 0; c < 12; c++) begin
            valid_i = (c <= 9);
            ready_i = 1'b1;
            clr     = (c == 3);
            to_sample();
            chk_bit($sformatf("fd5_clr_valid c%0d", c), vo[3], (c == 9));
            chk_bit($sformatf("fd5_clr_ready c%0d", c), ro[3], (c == 9));
            to_drive();
        end
        clr = 1'b0;

        // ---------------- FixedDelay=5, async reset pulse mid-count ----------------
        do_reset();
        for (int c = 0; c < 11; c++) begin
            valid_i = (c <= 8);
            ready_i = 1'b1;
            if (c == 3) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            to_sample();
            chk_bit($sformatf("fd5_rst_valid c%0d", c), vo[3], (c == 8));
            to_drive();
        end

        // ---------------- random delays vs reference model ----------------
        begin
            logic [15:0] m_lfsr;
            int          pops;
            m_lfsr = 16'hACE1;
            pops   = 0;
            do_reset();
            for (int n = 0; n < 200; n++) begin
                byte_t d;
                byte_t pay;
                int    k;
                bit    done;
                bit    seen;
                int    gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    valid_i = 1'b0;
                    ready_i = 1'($urandom_range(0, 1));
                    to_sample();
                    chk_bit($sformatf("rnd_gap_valid n%0d", n), vo[4], 1'b0);
                    to_drive();
                end
                d      = 8'(m_lfsr & 16'h000F);
                m_lfsr = model_lfsr_step(m_lfsr);
                pay    = 8'($urandom);
                exp_q.push_back(pay);
                valid_i   = 1'b1;
                payload_i = pay;
                k    = 0;
                done = 1'b0;
                seen = 1'b0;
                while (!done && k < 64) begin
                    logic ev;
                    ready_i = ($urandom_range(0, 3) != 0);
                    ev = (k >= int'(d));
                    to_sample();
                    chk_bit($sformatf("rnd_valid n%0d k%0d", n, k), vo[4], ev);
                    chk_bit($sformatf("rnd_ready n%0d k%0d", n, k), ro[4], ev & ready_i);
                    if (vo[4] && !seen) begin
                        seen = 1'b1;
                        chk_bit($sformatf("rnd_delay_range n%0d", n), (k <= 15), 1'b1);
                        chk_byte($sformatf("rnd_delay n%0d", n), 8'(k), d);
                    end
                    if (vo[4] && ready_i) begin
                        if (exp_q.size() == 0) begin
                            chk_bit($sformatf("rnd_dup_payload n%0d", n), 1'b1, 1'b0);
                        end else begin
                            chk_byte($sformatf("rnd_payload n%0d", n), po[4], exp_q.pop_front());
                            pops++;
                        end
                    end
                    if (ev && ready_i) done = 1'b1;
                    to_drive();
                    k++;
                end
                if (!done) chk_bit($sformatf("rnd_timeout n%0d", n), 1'b0, 1'b1);
                valid_i = 1'b0;
            end
            chk_byte("rnd_queue_empty", 8'(exp_q.size()), 8'd0);
            chk_byte("rnd_transfers", 8'(pops), 8'd200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
